// File: rtl/multdiv_sequencer_if.sv
// Handshake/data bundle between the pipeline and the multiply/divide sequencer.
// Latency: none (wires only).
// Backpressure: none in the bundle; the requester watches busy and data_resultRDY.
//
// Signals:
//   ctrl_MULT, ctrl_DIV            start pulses (requester -> sequencer)
//   data_operandA, data_operandB   two's complement operands (requester -> sequencer)
//   data_result, data_exception    result word and overflow/div-by-zero flag (sequencer -> requester)
//   data_resultRDY                 one-cycle result-valid pulse (sequencer -> requester)
//   busy                           operation in flight (sequencer -> requester)
// Modports: master = requester side, slave = sequencer side.
interface multdiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_MULT,
        output ctrl_DIV,
        output data_operandA,
        output data_operandB,
        input  data_result,
        input  data_exception,
        input  data_resultRDY,
        input  busy
    );

    modport slave (
        input  ctrl_MULT,
        input  ctrl_DIV,
        input  data_operandA,
        input  data_operandB,
        output data_result,
        output data_exception,
        output data_resultRDY,
        output busy
    );
endinterface

// File: rtl/multdiv_sequencer.sv
// Multicycle signed multiply (shift-add) / divide (restoring) sequencer beside the ALU.
// Latency: data_resultRDY in the cycle after start edge + WIDTH; divide-by-zero in the cycle after the start edge.
// Backpressure: none; starts while busy are dropped, so the pipeline must stall on busy.
//
// Ports:
//   clock   rising-edge clock
//   reset   synchronous, active-high; aborts any operation without a result pulse
//   mdif    multdiv_sequencer_if.slave: ctrl_MULT/ctrl_DIV/data_operandA/data_operandB in,
//           data_result/data_exception/data_resultRDY/busy out
// Parameters: WIDTH operand/result width (iterations per op), CNT_W iteration counter width.
// Build option: define MULTDIV_EARLY_EXIT_EN to let a multiply finish as soon as the
// remaining multiplier magnitude is zero (divide latency unchanged).
module multdiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    multdiv_sequencer_if.slave   mdif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Most negative value; also the largest magnitude a negative result may carry.
    localparam logic [WIDTH-1:0]   MIN_W = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [2*WIDTH-1:0] MIN_P = {{WIDTH{1'b0}}, MIN_W};
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WIDTH - 1);

    state_t               state_q;
    state_t               state_nxt;

    logic [CNT_W-1:0]     cnt_q;
    logic                 sign_q;

    // multiply datapath: multiplicand shifts left, multiplier shifts right
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;

    // divide datapath: quotient register starts as the dividend and is
    // shifted out into the partial remainder one bit per iteration
    logic [WIDTH-1:0]     rem_q;
    logic [WIDTH-1:0]     quo_q;
    logic [WIDTH-1:0]     divisor_q;

    logic [WIDTH-1:0]     result_q;
    logic                 exc_q;

    // combinational helpers
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic                 op_sign;
    logic                 b_zero;

    logic [2*WIDTH-1:0]   acc_step;
    logic                 mul_skip;
    logic                 mul_last;
    logic [2*WIDTH-1:0]   prod_fin;
    logic [WIDTH-1:0]     mul_res;
    logic                 mul_exc;

    logic [WIDTH:0]       r_sh;
    logic                 div_ge;
    logic [WIDTH-1:0]     r_sub;
    logic [WIDTH-1:0]     rem_nxt;
    logic [WIDTH-1:0]     quo_nxt;
    logic [WIDTH-1:0]     div_res;
    logic                 div_exc;
    logic                 div_last;

    logic                 load_op;
    logic                 div_zero;
    logic                 mul_done;
    logic                 div_done;

    // ------------------------------------------------------------------
    // Operand conditioning. Negating MIN_INT yields MIN_INT, which read as
    // unsigned is exactly its magnitude, so no extra width is needed.
    // ------------------------------------------------------------------
    always_comb begin
        abs_a   = mdif.data_operandA[WIDTH-1] ? -mdif.data_operandA : mdif.data_operandA;
        abs_b   = mdif.data_operandB[WIDTH-1] ? -mdif.data_operandB : mdif.data_operandB;
        op_sign = mdif.data_operandA[WIDTH-1] ^ mdif.data_operandB[WIDTH-1];
        b_zero  = (mdif.data_operandB == '0);
    end

    // ------------------------------------------------------------------
    // Multiply iteration and final result formatting
    // ------------------------------------------------------------------
`ifdef MULTDIV_EARLY_EXIT_EN
    // Nothing left to add once the shifted multiplier is empty.
    assign mul_skip = (mplier_q == '0);
`else
    assign mul_skip = 1'b0;
`endif

    always_comb begin
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        mul_last = (cnt_q == LAST) || mul_skip;
        // An early exit skips the iteration at that edge, so the accumulator
        // already holds the full product.
        prod_fin = mul_skip ? acc_q : acc_step;
        // Low bits of the negated product equal the negation of the low bits.
        mul_res  = sign_q ? -prod_fin[WIDTH-1:0] : prod_fin[WIDTH-1:0];
        // Positive results fit up to 2^(W-1)-1, negative ones down to -2^(W-1).
        mul_exc  = sign_q ? (prod_fin > MIN_P) : (prod_fin >= MIN_P);
    end

    // ------------------------------------------------------------------
    // Restoring divide iteration and final result formatting
    // ------------------------------------------------------------------
    always_comb begin
        r_sh     = {rem_q, quo_q[WIDTH-1]};
        div_ge   = (r_sh >= {1'b0, divisor_q});
        // When div_ge holds the difference is below the divisor, so W bits suffice.
        r_sub    = r_sh[WIDTH-1:0] - divisor_q;
        rem_nxt  = div_ge ? r_sub : r_sh[WIDTH-1:0];
        quo_nxt  = {quo_q[WIDTH-2:0], div_ge};
        div_last = (cnt_q == LAST);
        div_res  = sign_q ? -quo_nxt : quo_nxt;
        // Only MIN_INT / -1 produces a positive magnitude of 2^(W-1).
        div_exc  = !sign_q && (quo_nxt == MIN_W);
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        load_op   = 1'b0;
        div_zero  = 1'b0;
        mul_done  = 1'b0;
        div_done  = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                // MUL has priority when both starts arrive together.
                if (mdif.ctrl_MULT) begin
                    load_op   = 1'b1;
                    state_nxt = MUL;
                end else if (mdif.ctrl_DIV) begin
                    if (b_zero) begin
                        div_zero  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        load_op   = 1'b1;
                        state_nxt = DIV;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            MUL: begin
                if (mul_last) begin
                    mul_done  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DIV: begin
                if (div_last) begin
                    div_done  = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers. Both datapaths are loaded on any accepted start;
    // only the one matching the next state is ever iterated.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            result_q  <= '0;
            exc_q     <= 1'b0;
        end else begin
            if (load_op) begin
                cnt_q     <= '0;
                sign_q    <= op_sign;
                acc_q     <= '0;
                mcand_q   <= {{WIDTH{1'b0}}, abs_a};
                mplier_q  <= abs_b;
                rem_q     <= '0;
                quo_q     <= abs_a;
                divisor_q <= abs_b;
            end else if (state_q == MUL) begin
                cnt_q    <= cnt_q + 1'b1;
                acc_q    <= acc_step;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
            end else if (state_q == DIV) begin
                cnt_q <= cnt_q + 1'b1;
                rem_q <= rem_nxt;
                quo_q <= quo_nxt;
            end

            // Result registers change only on entry to DONE.
            if (div_zero) begin
                result_q <= '0;
                exc_q    <= 1'b1;
            end else if (mul_done) begin
                result_q <= mul_res;
                exc_q    <= mul_exc;
            end else if (div_done) begin
                result_q <= div_res;
                exc_q    <= div_exc;
            end
        end
    end

    assign mdif.data_result    = result_q;
    assign mdif.data_exception = exc_q;
    assign mdif.data_resultRDY = (state_q == DONE);
    assign mdif.busy           = (state_q == MUL) || (state_q == DIV);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: hand-computed products/quotients,
// latency, busy, result hold, start filtering and reset abort.
// Inputs driven and outputs sampled on the falling edge.
module tb_multdiv_sequencer;

    localparam int WIDTH = 32;

`ifdef MULTDIV_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clock;
    logic reset;

    int n_tests = 0;
    int n_fail  = 0;

    multdiv_sequencer_if #(.WIDTH(WIDTH)) mdif ();

    multdiv_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clock (clock),
        .reset (reset),
        .mdif  (mdif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Edges after the start edge until data_resultRDY, for a multiply by b.
    function automatic int exp_mul_lat(input logic [31:0] b);
        logic [31:0] m;
        int p;
        m = b[31] ? -b : b;
        p = -1;
        for (int i = 0; i < 32; i++) if (m[i]) p = i;
        return EARLY ? ((p + 2 > WIDTH) ? WIDTH : p + 2) : WIDTH;
    endfunction

    // Drive a start for one cycle; returns in the cycle after the start edge.
    task automatic start_op(input logic mul, input logic div, input logic [31:0] a, input logic [31:0] b);
        mdif.ctrl_MULT     = mul;
        mdif.ctrl_DIV      = div;
        mdif.data_operandA = a;
        mdif.data_operandB = b;
        @(negedge clock);
        mdif.ctrl_MULT     = 1'b0;
        mdif.ctrl_DIV      = 1'b0;
        // operands are don't-care after the accepting edge
        mdif.data_operandA = $urandom();
        mdif.data_operandB = $urandom();
    endtask

    // k = edges since the start edge. Optionally pulse ctrl_DIV at step div_at.
    task automatic wait_rdy(input int div_at, output int lat, output logic [31:0] res,
                            output logic exc, output logic busy_all, output logic busy_any);
        lat      = -1;
        res      = '0;
        exc      = 1'b0;
        busy_all = 1'b1;
        busy_any = 1'b0;
        for (int k = 0; k <= 100; k++) begin
            if (mdif.data_resultRDY) begin
                lat = k;
                res = mdif.data_result;
                exc = mdif.data_exception;
                break;
            end
            busy_any = busy_any | mdif.busy;
            busy_all = busy_all & mdif.busy;
            if (k == div_at) mdif.ctrl_DIV = 1'b1;
            @(negedge clock);
            mdif.ctrl_DIV = 1'b0;
        end
        if (lat < 0) check("rdy_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_op(input string tag, input logic mul, input logic div,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_exc, input int exp_lat,
                         input int div_at);
        int lat;
        logic [31:0] res;
        logic exc, ball, bany;
        start_op(mul, div, a, b);
        wait_rdy(div_at, lat, res, exc, ball, bany);
        check({tag, "_res"}, 64'(res), 64'(exp_res));
        check({tag, "_exc"}, 64'(exc), 64'(exp_exc));
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        if (exp_lat > 0) check({tag, "_busy"}, 64'(ball), 64'd1);
        else             check({tag, "_nobusy"}, 64'(bany), 64'd0);
        @(negedge clock);
        check({tag, "_pulse"}, 64'(mdif.data_resultRDY), 64'd0);
        check({tag, "_hold"}, 64'(mdif.data_result), 64'(exp_res));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [31:0] res;
        logic exc, ball, bany, seen;

        reset              = 1'b1;
        mdif.ctrl_MULT     = 1'b0;
        mdif.ctrl_DIV      = 1'b0;
        mdif.data_operandA = '0;
        mdif.data_operandB = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("rst_res",  64'(mdif.data_result),    64'd0);
        check("rst_exc",  64'(mdif.data_exception), 64'd0);
        check("rst_rdy",  64'(mdif.data_resultRDY), 64'd0);
        check("rst_busy", 64'(mdif.busy),           64'd0);

        // multiply
        do_op("m7x-3",   1, 0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 0, exp_mul_lat(32'hFFFFFFFD), -1);
        do_op("movf",    1, 0, 32'h40000000,   32'd2,        32'h80000000, 1, exp_mul_lat(32'd2),        -1);
        do_op("mm1xm1",  1, 0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'd1,        0, exp_mul_lat(32'hFFFFFFFF), -1);
        do_op("mminx1",  1, 0, 32'h80000000,   32'd1,        32'h80000000, 0, exp_mul_lat(32'd1),        -1);
        do_op("mminxm1", 1, 0, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1, exp_mul_lat(32'hFFFFFFFF), -1);
        do_op("mneg32",  1, 0, 32'hFFFF0000,   32'h00010000, 32'd0,        1, exp_mul_lat(32'h00010000), -1);
        do_op("m123x0",  1, 0, 32'd123,        32'd0,        32'd0,        0, exp_mul_lat(32'd0),        -1);

        // divide
        do_op("d-100/7", 0, 1, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2, 0, WIDTH, -1);
        do_op("dmin/m1", 0, 1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1, WIDTH, -1);
        do_op("dmin/1",  0, 1, 32'h80000000,   32'd1,        32'h80000000, 0, WIDTH, -1);
        do_op("d7/-2",   0, 1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 0, WIDTH, -1);
        do_op("d5/0",    0, 1, 32'd5,          32'd0,        32'd0,        1, 0,     -1);

        // both starts together: MUL wins (6*3, not 6/3)
        do_op("both",    1, 1, 32'd6,          32'd3,        32'd18,       0, exp_mul_lat(32'd3), -1);

        // ctrl_DIV pulsed mid-multiply at count 10 is ignored
        do_op("mdivign", 1, 0, 32'd1234,       32'hFFFFE9D2, 32'hFF951644, 0, exp_mul_lat(32'hFFFFE9D2), 10);

        // reset mid-multiply aborts without a result pulse
        start_op(1, 0, 32'd9, 32'h40000001);
        repeat (15) @(negedge clock);
        check("abort_busy_pre", 64'(mdif.busy), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            seen = seen | mdif.data_resultRDY;
            @(negedge clock);
        end
        check("abort_no_rdy", 64'(seen), 64'd0);
        check("abort_busy",   64'(mdif.busy), 64'd0);
        check("abort_res",    64'(mdif.data_result), 64'd0);
        do_op("post_rst", 1, 0, 32'd6, 32'd7, 32'd42, 0, exp_mul_lat(32'd7), -1);

        // back-to-back: new start accepted in the DONE cycle
        start_op(1, 0, 32'd3, 32'd4);
        wait_rdy(-1, lat, res, exc, ball, bany);
        check("b2b_first_res", 64'(res), 64'd12);
        check("b2b_first_lat", 64'(lat), 64'(exp_mul_lat(32'd4)));
        start_op(0, 1, 32'd100, 32'hFFFFFFF6);
        check("b2b_busy", 64'(mdif.busy), 64'd1);
        wait_rdy(-1, lat, res, exc, ball, bany);
        check("b2b_second_res", 64'(res), 64'hFFFFFFF6);
        check("b2b_second_exc", 64'(exc), 64'd0);
        check("b2b_second_lat", 64'(lat), 64'(WIDTH));
        @(negedge clock);
        check("b2b_idle", 64'(mdif.data_resultRDY), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
